// File: rtl/sum_display_ctrl.sv
// Captures the adder's sum, converts it to two BCD digits with an iterative double-dabble FSM,
// and scans them onto a 2-digit active-low 7-segment display. Option macro: LEADING_ZERO_BLANK_EN.
module sum_display_ctrl #(
  parameter int SUM_W        = 5,
  parameter int REFRESH_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [1:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   bin_q, bin_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [1:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic [7:0]         adj_s;
  logic [SUM_W+7:0]   shift_s;
  logic [3:0]         digit_s;
  logic               slot_tens_s;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM: add-3 adjust then shift {bcd,bin}, one bit per CONV cycle
  always_comb begin
    adj_s[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj_s[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shift_s    = {adj_s, bin_q} << 1;

    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d   = sum;
          bcd_d   = 8'd0;
          cnt_d   = 3'd0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d = shift_s[SUM_W+7:SUM_W];
        bin_d = shift_s[SUM_W-1:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(SUM_W - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // Scan slot selection and segment encoding; registered below so an/seg never glitch
  always_comb begin
    scan_d      = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    slot_tens_s = scan_q[REFRESH_BITS-1];
    digit_s     = slot_tens_s ? tens_q : ones_q;
    an_d        = slot_tens_s ? 2'b01 : 2'b10;
    seg_d       = seg_enc(digit_s);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot_tens_s && (tens_q == 4'd0)) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_enc(digit_s);
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= 8'd0;
      cnt_q   <= 3'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scan_q  <= '0;
      an_q    <= 2'b10;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_sum_display_ctrl.sv
// Directed, scoreboard-based bench for sum_display_ctrl (SUM_W=5, REFRESH_BITS=4).
module tb_sum_display_ctrl;

  logic       clk;
  logic       rst;
  logic       load;
  logic [4:0] sum;
  logic       busy;
  logic       done;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  logic [7:0] sb_q[$];
  logic [6:0] enc_tab [0:9];

  sum_display_ctrl #(.SUM_W(5), .REFRESH_BITS(4)) dut (
    .clk(clk), .rst(rst), .load(load), .sum(sum),
    .busy(busy), .done(done), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] tens_seg(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 4'd0) return 7'b1111111;
`endif
    return enc_tab[t];
  endfunction

  // Pulse load for one edge and push the expected digits
  task automatic do_load(input logic [4:0] v);
    @(negedge clk);
    sum  = v;
    load = 1'b1;
    sb_q.push_back({4'(v / 5'd10), 4'(v % 5'd10)});
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_display(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (an !== 2'b10 && n < 20) begin n++; @(negedge clk); end
    chk({tag, "_ones_an"}, an, 2'b10);
    chk({tag, "_ones_seg"}, seg, enc_tab[exp[3:0]]);
    n = 0;
    while (an !== 2'b01 && n < 20) begin n++; @(negedge clk); end
    chk({tag, "_tens_an"}, an, 2'b01);
    chk({tag, "_tens_seg"}, seg, tens_seg(exp[7:4]));
  endtask

  // Wait for done (bounded), check latency/busy width, pop scoreboard, check display
  task automatic wait_done(input string tag, input int exp_lat);
    int n, nb;
    logic [7:0] exp;
    n = 0; nb = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nb++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_lat);
    chk({tag, "_busy_low_at_done"}, busy, 1'b0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      exp = 8'h00;
    end else begin
      exp = sb_q.pop_front();
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    check_display(tag, exp);
  endtask

  initial begin
    int dc;
    logic [1:0] an_hist [0:31];
    enc_tab[0] = 7'b1000000; enc_tab[1] = 7'b1111001; enc_tab[2] = 7'b0100100;
    enc_tab[3] = 7'b0110000; enc_tab[4] = 7'b0011001; enc_tab[5] = 7'b0010010;
    enc_tab[6] = 7'b0000010; enc_tab[7] = 7'b1111000; enc_tab[8] = 7'b0000000;
    enc_tab[9] = 7'b0010000;

    rst = 1'b1; load = 1'b0; sum = 5'd0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_dp", dp, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_load(5'd31);
    wait_done("s31", 6);

    do_load(5'd0);
    wait_done("s0", 6);
    do_load(5'd19);
    wait_done("s19", 6);

    // Second load two cycles after the first must be ignored
    dc = done_cnt;
    do_load(5'd12);
    @(negedge clk);
    sum = 5'd25; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("s12", 4);
    repeat (10) @(negedge clk);
    chk("ignore_done_count", done_cnt - dc, 1);
    chk("ignore_sb_empty", sb_q.size(), 0);
    check_display("s12_hold", 8'h12);

    // Scan period while a conversion runs
    dc = done_cnt;
    do_load(5'd9);
    for (int i = 0; i < 32; i++) begin
      an_hist[i] = an;
      @(negedge clk);
    end
    for (int i = 0; i < 24; i++) begin
      chk("scan_onehot", (an_hist[i] == 2'b10 || an_hist[i] == 2'b01), 1'b1);
      chk("scan_half", (an_hist[i] != an_hist[i+8]), 1'b1);
    end
    chk("scan_done_count", done_cnt - dc, 1);
    check_display("s9", sb_q.pop_front());

    // Reset in the middle of converting 27
    dc = done_cnt;
    do_load(5'd27);
    void'(sb_q.pop_back());
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_an", an, 2'b10);
    chk("midrst_seg", seg, 7'b1000000);
    chk("midrst_dp", dp, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc, 0);
    check_display("midrst", 8'h00);

    do_load(5'd7);
    wait_done("s7", 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
